// File: rtl/commit_trace_fifo.sv
// Commit trace recorder: turns writeback commit activity into numbered trace records in an FWFT FIFO.
// Define TRACE_SKIP_EN to also record idle cycles as kind-0 skip records.
module commit_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int WARMUP = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_we,
  input  logic [4:0]  reg_waddr,
  input  logic [31:0] reg_wdata,
  input  logic        hilo_we,
  input  logic [31:0] hi_data,
  input  logic [31:0] lo_data,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic        clear,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [1:0]  rec_kind,
  output logic [15:0] rec_index,
  output logic [4:0]  rec_addr,
  output logic [31:0] rec_data0,
  output logic [31:0] rec_data1,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WW-1:0] WARM_LAST = (WARMUP > 0) ? WW'(WARMUP - 1) : '0;

`ifdef TRACE_SKIP_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  typedef enum logic {WARM, RUN} state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] index;
    logic [4:0]  addr;
    logic [31:0] data0;
    logic [31:0] data1;
  } rec_t;

  state_t        state;
  logic [WW-1:0] warm_cnt;
  logic [15:0]   idx_cnt;

  rec_t          rec_new;
  rec_t          head;
  rec_t          mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          any_we;
  logic          rec_gen;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= (WARMUP == 0) ? RUN : WARM;
      warm_cnt <= '0;
      idx_cnt  <= '0;
    end else if (state == WARM) begin
      warm_cnt <= warm_cnt + 1'b1;
      if (warm_cnt == WARM_LAST) state <= RUN;
    end else begin
      idx_cnt <= idx_cnt + 16'd1;
    end
  end

  // Priority gpr > hilo > cp0; the record carries the index value the counter is about to take.
  always_comb begin
    rec_new       = '0;
    rec_new.index = idx_cnt + 16'd1;
    if (reg_we) begin
      rec_new.kind  = 2'd1;
      rec_new.addr  = reg_waddr;
      rec_new.data0 = reg_wdata;
    end else if (hilo_we) begin
      rec_new.kind  = 2'd2;
      rec_new.data0 = hi_data;
      rec_new.data1 = lo_data;
    end else if (cp0_we) begin
      rec_new.kind  = 2'd3;
      rec_new.addr  = cp0_waddr;
      rec_new.data0 = cp0_wdata;
    end
  end

  assign any_we  = reg_we | hilo_we | cp0_we;
  assign rec_gen = (state == RUN) && (any_we || SKIP_EN);

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && rec_ready;
  assign push  = rec_gen && !clear && (!full || pop);
  assign drop  = rec_gen && !clear && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= rec_new;
  end

  assign head      = empty ? '0 : mem[rptr[AW-1:0]];
  assign rec_valid = !empty;
  assign rec_kind  = head.kind;
  assign rec_index = head.index;
  assign rec_addr  = head.addr;
  assign rec_data0 = head.data0;
  assign rec_data1 = head.data1;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Scoreboard bench for commit_trace_fifo (DEPTH 16, WARMUP 5); adapts to TRACE_SKIP_EN.
module tb_commit_trace_fifo;

  localparam int DEPTH  = 16;
  localparam int WARMUP = 5;
`ifdef TRACE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] idx;
    logic [4:0]  addr;
    logic [31:0] d0;
    logic [31:0] d1;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_we = 1'b0;
  logic [4:0]  reg_waddr = '0;
  logic [31:0] reg_wdata = '0;
  logic        hilo_we = 1'b0;
  logic [31:0] hi_data = '0;
  logic [31:0] lo_data = '0;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_waddr = '0;
  logic [31:0] cp0_wdata = '0;
  logic        clear = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [1:0]  rec_kind;
  logic [15:0] rec_index;
  logic [4:0]  rec_addr;
  logic [31:0] rec_data0;
  logic [31:0] rec_data1;
  logic        overflow;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  rec_t        q[$];
  bit          m_run;
  int          m_warm;
  logic [15:0] m_idx;
  bit          m_ovf;
  int          m_drop;

  commit_trace_fifo #(.DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .hilo_we(hilo_we), .hi_data(hi_data), .lo_data(lo_data),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .clear(clear),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_kind(rec_kind), .rec_index(rec_index), .rec_addr(rec_addr),
    .rec_data0(rec_data0), .rec_data1(rec_data1),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    reg_we = 1'b0; hilo_we = 1'b0; cp0_we = 1'b0; clear = 1'b0;
  endtask

  task automatic gpr(input logic [4:0] a, input logic [31:0] d);
    idle_inputs(); reg_we = 1'b1; reg_waddr = a; reg_wdata = d;
  endtask

  // Compare DUT against the scoreboard, advance the model for this edge, then clock.
  task automatic tick();
    rec_t r;
    rec_t got;
    bit   pop;
    bit   full_b;
    bit   gen;
    checks++;
    if (rec_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL sb_valid got %0b want %0b (t=%0t)", rec_valid, q.size() != 0, $time);
    end
    if (q.size() != 0) begin
      got = {rec_kind, rec_index, rec_addr, rec_data0, rec_data1};
      checks++;
      if (got !== q[0]) begin
        errors++;
        $display("FAIL sb_head got %h want %h (t=%0t)", got, q[0], $time);
      end
    end
    checks++;
    if (overflow !== m_ovf || drop_count !== 8'(m_drop)) begin
      errors++;
      $display("FAIL sb_drop got ovf=%0b cnt=%0d want ovf=%0b cnt=%0d", overflow, drop_count, m_ovf, m_drop);
    end
    pop    = (q.size() != 0) && rec_ready;
    full_b = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (clear) begin
      q.delete(); m_ovf = 1'b0; m_drop = 0;
    end
    if (m_run) begin
      m_idx = m_idx + 16'd1;
      r = '0;
      r.idx = m_idx;
      gen = 1'b1;
      if (reg_we) begin
        r.kind = 2'd1; r.addr = reg_waddr; r.d0 = reg_wdata;
      end else if (hilo_we) begin
        r.kind = 2'd2; r.d0 = hi_data; r.d1 = lo_data;
      end else if (cp0_we) begin
        r.kind = 2'd3; r.addr = cp0_waddr; r.d0 = cp0_wdata;
      end else begin
        gen = SKIP;
      end
      if (gen && !clear) begin
        if (!full_b || pop) q.push_back(r);
        else begin
          m_ovf = 1'b1;
          if (m_drop != 255) m_drop++;
        end
      end
    end else begin
      m_warm++;
      if (m_warm >= WARMUP) m_run = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; #1;
    rst = 1'b0; #1;
    checks++;
    if (rec_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0 || rec_kind !== 2'd0 ||
        rec_index !== 16'd0 || rec_addr !== 5'd0 || rec_data0 !== 32'd0 || rec_data1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%0b ovf=%0b cnt=%0d kind=%0d idx=%0d want all 0",
               rec_valid, overflow, drop_count, rec_kind, rec_index);
    end
    q.delete(); m_run = (WARMUP == 0); m_warm = 0; m_idx = '0; m_ovf = 1'b0; m_drop = 0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rec_ready = 1'b1;
    apply_reset();
    repeat (WARMUP) tick();
  endtask

  task automatic test_record_kinds();
    gpr(5'd1, 32'h0000_1100);
    tick();
    checks++;
    if (rec_valid !== 1'b1 || rec_kind !== 2'd1 || rec_index !== 16'd1 || rec_addr !== 5'd1 || rec_data0 !== 32'h1100) begin
      errors++;
      $display("FAIL first_gpr got v=%0b k=%0d i=%0d a=%0d d0=%h want v=1 k=1 i=1 a=1 d0=00001100",
               rec_valid, rec_kind, rec_index, rec_addr, rec_data0);
    end
    idle_inputs();
    tick();
    checks++;
    if (SKIP) begin
      if (rec_valid !== 1'b1 || rec_kind !== 2'd0 || rec_index !== 16'd2 || rec_data0 !== 32'd0) begin
        errors++;
        $display("FAIL skip_rec got v=%0b k=%0d i=%0d want v=1 k=0 i=2", rec_valid, rec_kind, rec_index);
      end
    end else if (rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_skip_rec got v=%0b want 0", rec_valid);
    end
    idle_inputs(); hilo_we = 1'b1; hi_data = 32'hFFFF_0000; lo_data = 32'h0000_0005;
    tick();
    checks++;
    if (rec_kind !== 2'd2 || rec_index !== 16'd3 || rec_addr !== 5'd0 || rec_data0 !== 32'hFFFF_0000 || rec_data1 !== 32'h5) begin
      errors++;
      $display("FAIL hilo_rec got k=%0d i=%0d a=%0d d0=%h d1=%h want k=2 i=3 a=0 d0=ffff0000 d1=00000005",
               rec_kind, rec_index, rec_addr, rec_data0, rec_data1);
    end
    idle_inputs(); cp0_we = 1'b1; cp0_waddr = 5'd11; cp0_wdata = 32'h0000_0100;
    tick();
    checks++;
    if (rec_kind !== 2'd3 || rec_index !== 16'd4 || rec_addr !== 5'd11 || rec_data0 !== 32'h100 || rec_data1 !== 32'd0) begin
      errors++;
      $display("FAIL cp0_rec got k=%0d i=%0d a=%0d d0=%h want k=3 i=4 a=11 d0=00000100",
               rec_kind, rec_index, rec_addr, rec_data0);
    end
  endtask

  task automatic test_priority();
    gpr(5'd7, 32'hA5A5_A5A5); hilo_we = 1'b1; cp0_we = 1'b1;
    tick();
    checks++;
    if (rec_kind !== 2'd1 || rec_index !== 16'd5 || rec_addr !== 5'd7 || rec_data0 !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL priority got k=%0d i=%0d a=%0d d0=%h want k=1 i=5 a=7 d0=a5a5a5a5",
               rec_kind, rec_index, rec_addr, rec_data0);
    end
    gpr(5'd0, 32'h1234_5678);
    tick();
    checks++;
    if (rec_kind !== 2'd1 || rec_index !== 16'd6 || rec_addr !== 5'd0 || rec_data0 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL gpr_r0_next got k=%0d i=%0d a=%0d want k=1 i=6 a=0", rec_kind, rec_index, rec_addr);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_overflow();
    idle_inputs();
    rec_ready = 1'b0;
    apply_reset();
    repeat (WARMUP) tick();
    for (int i = 0; i < 20; i++) begin
      gpr(5'(i), 32'h100 + 32'(i));
      tick();
    end
    idle_inputs();
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd4 || rec_index !== 16'd1 || rec_data0 !== 32'h100) begin
      errors++;
      $display("FAIL overflow got ovf=%0b cnt=%0d head=%0d want ovf=1 cnt=4 head=1", overflow, drop_count, rec_index);
    end
    rec_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (rec_valid !== 1'b1 || rec_index !== 16'(i)) begin
        errors++;
        $display("FAIL drain_order got v=%0b i=%0d want v=1 i=%0d", rec_valid, rec_index, i);
      end
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0 || rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear got ovf=%0b cnt=%0d v=%0b want 0 0 0", overflow, drop_count, rec_valid);
    end
  endtask

  task automatic test_back_to_back();
    rec_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      gpr(5'd3, 32'h200 + 32'(i));
      tick();
    end
    rec_ready = 1'b1;
    repeat (3) begin
      gpr(5'd4, 32'h300);
      tick();
    end
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL full_pushpop got ovf=%0b cnt=%0d want 0 0", overflow, drop_count);
    end
    rec_ready = 1'b0;
    gpr(5'd5, 32'h400);
    tick();
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL still_full got ovf=%0b cnt=%0d want 1 1", overflow, drop_count);
    end
    rec_ready = 1'b1;
    tick();
    apply_reset();
    repeat (WARMUP) begin
      gpr(5'd9, 32'hDEAD);
      tick();
    end
    checks++;
    if (rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL warmup_ignored got v=%0b want 0", rec_valid);
    end
    gpr(5'd2, 32'h55);
    tick();
    checks++;
    if (rec_valid !== 1'b1 || rec_index !== 16'd1 || rec_addr !== 5'd2) begin
      errors++;
      $display("FAIL post_reset_first got v=%0b i=%0d a=%0d want v=1 i=1 a=2", rec_valid, rec_index, rec_addr);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_gaps();
    int gidx[$];
    int skips;
    skips = 0;
    idle_inputs();
    rec_ready = 1'b1;
    apply_reset();
    repeat (WARMUP) tick();
    for (int c = 1; c <= 8; c++) begin
      if (rec_valid && rec_ready) begin
        if (rec_kind == 2'd0) skips++;
        else gidx.push_back(int'(rec_index));
      end
      if (c == 1 || c == 4) gpr(5'd6, 32'(c));
      else idle_inputs();
      tick();
    end
    checks++;
    if (gidx.size() != 2 || gidx[0] != 1 || gidx[1] != 4) begin
      errors++;
      $display("FAIL gap_indices got n=%0d first=%0d second=%0d want n=2 1 4", gidx.size(),
               gidx.size() > 0 ? gidx[0] : -1, gidx.size() > 1 ? gidx[1] : -1);
    end
    checks++;
    if (SKIP ? (skips < 3) : (skips != 0)) begin
      errors++;
      $display("FAIL skip_count got %0d want %s", skips, SKIP ? ">=3" : "0");
    end
  endtask

  initial begin
    test_reset();
    test_record_kinds();
    test_priority();
    test_overflow();
    test_back_to_back();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Downstream companion of the CPU core's writeback stage. Every cycle it samples the commit signals: GPR write, HI/LO write and CP0 write. It turns each cycle into a numbered trace record and buffers the records in a first-word-fall-through FIFO. A valid/ready consumer drains the FIFO, either a UART dumper on the board or a checker in simulation. The record format and numbering match the unit-test answer files, "N:$r=0x…", "N:hi=0x…,lo=0x…", "N:cp0.$r=0x…" and "N:skip", so on-chip traces can be compared against the same references.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- WARMUP, 5, cycles after reset release that are sampled but never recorded (pipeline fill).

Ports:
- clk  in  1  core clock; the single clock domain.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- reg_we  in  1  GPR write enable from writeback.
- reg_waddr  in  5  GPR write address.
- reg_wdata  in  32  GPR write data.
- hilo_we  in  1  HI/LO write enable.
- hi_data  in  32  HI value being written.
- lo_data  in  32  LO value being written.
- cp0_we  in  1  CP0 write enable.
- cp0_waddr  in  5  CP0 register address.
- cp0_wdata  in  32  CP0 write data.
- clear  in  1  synchronous flush of FIFO and error state.
- rec_valid  out  1  head record is available.
- rec_ready  in  1  consumer accepts the head record.
- rec_kind  out  2  0 = skip, 1 = gpr, 2 = hilo, 3 = cp0.
- rec_index  out  16  record number; the first recorded cycle is 1.
- rec_addr  out  5  register address (0 for skip and hilo).
- rec_data0  out  32  wdata for gpr/cp0, hi_data for hilo, 0 for skip.
- rec_data1  out  32  lo_data for hilo, 0 otherwise.
- overflow  out  1  sticky; set when a record has been dropped.
- drop_count  out  8  number of dropped records, saturating at 0xFF.

## Operation
- States: WARM and RUN.
  - Reset enters WARM with the warmup counter at 0.
  - WARM counts WARMUP sampled cycles, then moves to RUN.
  - With WARMUP = 0, the first cycle after reset release is already RUN.
- In RUN, every clock edge:
  - increments the index counter (reset value 0; wraps from 0xFFFF to 0x0000);
  - forms one record carrying the new index value.
- Record priority when several enables are high: reg_we, then hilo_we, then cp0_we. Only one record is produced per cycle and lower-priority events are discarded silently.
- reg_we with reg_waddr = 0 is still recorded as a gpr record with address 0.
- Skip records: a cycle with no enable high produces a kind-0 record only when the configuration macro is defined (see Configuration).
- Push rules:
  - A record is pushed if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the record is dropped: overflow is set to 1 and drop_count increments, saturating.
  - Dropped records still consume their index.
- Pop: happens when rec_valid && rec_ready. rec_valid = not empty. The head fields are stable while rec_valid && !rec_ready.
- clear:
  - empties the FIFO and zeroes overflow and drop_count;
  - leaves the index counter and the WARM/RUN state untouched;
  - a record sampled in the same cycle as clear is discarded.
- Reset values:
  - rec_valid = 0, overflow = 0, drop_count = 0, index = 0, state = WARM;
  - rec_kind, rec_index, rec_addr, rec_data0 and rec_data1 read 0 while the FIFO is empty.

## Timing
- Commit inputs are sampled at the rising edge.
- A record sampled at edge k is visible on rec_* with rec_valid = 1 in the cycle after edge k. Latency is 1 cycle into an empty FIFO.
- A pop at edge k presents the next entry in the cycle after edge k, with no bubble.
- With push and pop every cycle, a throughput of 1 record per cycle is sustained indefinitely.
- Asserting rst mid-operation immediately empties the FIFO and zeroes all outputs. The first record after release has index 1 and appears only after WARMUP cycles.
- Full and empty are derived from (log2(DEPTH)+1)-bit read and write pointers, so all DEPTH entries are usable.

## Configuration
- TRACE_SKIP_EN defined: idle cycles push kind-0 skip records, so indices in the FIFO are contiguous.
- TRACE_SKIP_EN undefined:
  - idle cycles push nothing but still advance the index, which leaves gaps in rec_index;
  - no kind-0 record is ever produced.

## Test plan
- Reset with WARMUP = 5, TRACE_SKIP_EN defined. On cycle 6 after release drive reg_we = 1, reg_waddr = 1, reg_wdata = 0x00001100; rec_ready = 1 throughout. Required: the first record is {kind 1, index 1, addr 1, data0 0x00001100}; an idle cycle next gives {kind 0, index 2}.
- Drive reg_we, hilo_we and cp0_we together in one cycle. Required: exactly one gpr record; the next index is consecutive.
- Drive hilo_we with hi_data = 0xFFFF0000, lo_data = 0x00000005 at index 3. Required: {kind 2, index 3, addr 0, data0 0xFFFF0000, data1 0x00000005}. Then drive cp0_we with cp0_waddr = 11, cp0_wdata = 0x00000100. Required: {kind 3, index 4, addr 11, data0 0x00000100}.
- Hold rec_ready = 0 with DEPTH = 16 for 20 RUN cycles. Required: 16 entries stored, overflow = 1, drop_count = 4, head fields held. Releasing rec_ready drains indices 1..16 in order. Then pulse clear. Required: overflow = 0, drop_count = 0.
- With the FIFO full, push and pop in the same cycle. Required: no drop and the occupancy stays at 16. Assert rst mid-stream. Required: rec_valid = 0 at once, and the first post-warmup record has index 1.
- Build with TRACE_SKIP_EN undefined; drive writes at RUN cycles 1 and 4 only. Required: exactly two records, with indices 1 and 4.
